memoria_instrucoes_param: RTL and testbench
===========================================

Name: memoria_instrucoes_param

Overview:
Parametrised instruction memory, the successor to the fixed 16x16 instruction store. It has a separate fetch (read) port and load (write) port, a configurable width and depth, and a boot sequencer. After reset the sequencer loads the default program into the array one word per cycle. It sits between the program counter / fetch stage and the program loader of the processor datapath.

Parameters:
DATA_WIDTH, 16, instruction word width in bits (must be >= 16).
ADDR_WIDTH, 4, address width; DEPTH = 2**ADDR_WIDTH words.

Ports:
Clock  input  1  single system clock; all state updates on rising edge.
Reset  input  1  synchronous, active-low reset (sampled on rising edge of Clock; 0 = reset).
Rd_en  input  1  fetch request.
Rd_addr  input  ADDR_WIDTH  fetch address.
Q  output  DATA_WIDTH  fetched instruction, registered.
Q_valid  output  1  Q holds the data for the fetch request of the previous cycle.
Wren  input  1  load-port write enable.
Wr_addr  input  ADDR_WIDTH  write address.
Din  input  DATA_WIDTH  write data.
Err_inject  input  1  when high with an accepted write, stores an inverted parity bit (active only with MEM_PARITY_EN).
Ready  output  1  boot load complete; ports accepted.
Parity_err  output  1  parity mismatch on the current Q (0 when the feature is compiled out).

Behaviour:
- Reset == 0 at a clock edge:
  - state <= BOOT, boot counter <= 0.
  - Ready, Q_valid, Parity_err <= 0; Q <= 0.
  - Reset asserted mid-BOOT or mid-RUN restarts BOOT from address 0.
- FSM states:
  - BOOT:
    - Each cycle writes boot_word(counter) to mem[counter], then increments the counter.
    - After writing address DEPTH-1, moves to RUN; Ready = 1 from the next cycle.
    - BOOT takes exactly DEPTH cycles after reset is released.
    - Rd_en, Wren and Err_inject are ignored; Q_valid stays 0 and Q holds 0.
  - RUN: stays in RUN until reset.
- Boot program, 16-bit encoding {op[2:0], rd[2:0], rs[2:0], rt[2:0], imm[3:0]}, ADD = 3'd2, SUB = 3'd3. The word is zero-extended in the MSBs when DATA_WIDTH > 16.
  - addr0 = 0x40A0
  - addr1 = 0x6000
  - addr2 = 0x40A1
  - addr3 = 0x60A2
  - addr4..6 = 0x40A0
  - all other addresses = 0x0000 (NOP)
  - When DEPTH < 8, only the addresses that exist are loaded.
- Read (RUN only):
  - Rd_en = 1 at edge N gives Q = mem[Rd_addr] and Q_valid = 1 after edge N (1-cycle latency).
  - Rd_en = 0 gives Q_valid <= 0; Q holds its last value.
  - Back-to-back reads give one result per cycle.
- Write (RUN only): Wren = 1 writes mem[Wr_addr] <= Din at the edge.
- Simultaneous read and write to the same address in the same cycle: write-first. Q returns Din, not the old contents.
- Simultaneous read and write to different addresses: independent, both complete.
- Addresses are always in range (full ADDR_WIDTH decode); there is no wrap or out-of-range case.
- All outputs are registered.

Optional Feature:
MEM_PARITY_EN
- Defined:
  - Each word stores an extra even-parity bit, the XOR of the data.
  - Boot words store correct parity.
  - A write with Err_inject = 1 stores the inverted parity bit.
  - On each read, Parity_err is registered alongside Q: 1 if the stored parity does not match the XOR of the stored data, else 0.
  - On the write-first bypass, Parity_err reflects the bit being written.
  - Parity_err is valid only when Q_valid = 1; otherwise it is 0.
- Not defined: no parity storage; Err_inject is ignored; Parity_err is tied to 0.

Test Plan:
1. Defaults (16/4): drop Reset to 0 for 2 cycles, release -> Ready = 0 for exactly 16 cycles then 1; reads of addr 0,1,2,3,7 give 0x40A0, 0x6000, 0x40A1, 0x60A2, 0x0000, each with Q_valid = 1 one cycle after request.
2. In RUN: write 0xBEEF to addr 5, next cycle read addr 5 -> Q = 0xBEEF; same-cycle write 0x1234 and read on addr 9 -> Q = 0x1234 (write-first).
3. Rd_en pulse on cycles 0,1, idle on cycle 2 -> Q_valid = 1,1,0; Q holds the last value on cycle 2.
4. Assert Reset at boot counter = 7 -> Ready stays 0, boot restarts at 0, Ready rises 16 cycles after release; a write to addr 3 issued during BOOT is lost, so addr 3 reads 0x60A2.
5. DATA_WIDTH = 32, ADDR_WIDTH = 6 -> Ready after 64 cycles; addr0 reads 0x000040A0; addr 63 reads 0.
6. With MEM_PARITY_EN: write 0x00FF with Err_inject = 1 to addr 2 -> read gives Parity_err = 1; rewrite with Err_inject = 0 -> Parity_err = 0; boot words read with Parity_err = 0.

Source files
------------

// File: rtl/memoria_instrucoes_param.sv
// Parametrised instruction store: registered fetch port, load port, and a boot loader for the default program.
// Build option MEM_PARITY_EN adds a stored even-parity bit per word and drives Parity_err.
module memoria_instrucoes_param #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Rd_en,
  input  logic [ADDR_WIDTH-1:0] Rd_addr,
  output logic [DATA_WIDTH-1:0] Q,
  output logic                  Q_valid,
  input  logic                  Wren,
  input  logic [ADDR_WIDTH-1:0] Wr_addr,
  input  logic [DATA_WIDTH-1:0] Din,
  input  logic                  Err_inject,
  output logic                  Ready,
  output logic                  Parity_err
);
  // state | meaning
  // BOOT  | loading default program, one word per cycle; ports ignored
  // RUN   | fetch and load ports active until reset
  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [0:0] BOOT = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]            state;
  logic [ADDR_WIDTH-1:0] boot_cnt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] boot_data;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  bypass;

  function automatic logic [15:0] boot_word(input logic [ADDR_WIDTH-1:0] a);
    logic [15:0] w;
    w = 16'h0000;
    case (32'(a))
      0:       w = 16'h40A0;
      1:       w = 16'h6000;
      2:       w = 16'h40A1;
      3:       w = 16'h60A2;
      4, 5, 6: w = 16'h40A0;
      default: w = 16'h0000;
    endcase
    return w;
  endfunction

  assign boot_data = DATA_WIDTH'(boot_word(boot_cnt));
  // write-first: a same-address write in the same cycle supplies the fetched word
  assign bypass    = Wren && (Wr_addr == Rd_addr);
  assign rd_data   = bypass ? Din : mem[Rd_addr];

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state    <= BOOT;
      boot_cnt <= '0;
      Ready    <= 1'b0;
      Q_valid  <= 1'b0;
      Q        <= '0;
    end else if (state == BOOT) begin
      boot_cnt <= boot_cnt + 1'b1;
      if (&boot_cnt) begin
        state <= RUN;
        Ready <= 1'b1;
      end
    end else begin
      Q_valid <= Rd_en;
      if (Rd_en) Q <= rd_data;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      if (state == BOOT)  mem[boot_cnt] <= boot_data;
      else if (Wren)      mem[Wr_addr]  <= Din;
    end
  end

`ifdef MEM_PARITY_EN
  logic mem_par [DEPTH];

  always_ff @(posedge Clock) begin
    if (Reset) begin
      if (state == BOOT)  mem_par[boot_cnt] <= ^boot_data;
      else if (Wren)      mem_par[Wr_addr]  <= (^Din) ^ Err_inject;
    end
  end

  // on bypass the stored bit differs from the data parity exactly when an error is injected
  always_ff @(posedge Clock) begin
    if (!Reset)                       Parity_err <= 1'b0;
    else if (state == RUN && Rd_en)   Parity_err <= bypass ? Err_inject
                                                           : (mem_par[Rd_addr] ^ (^mem[Rd_addr]));
    else                              Parity_err <= 1'b0;
  end
`else
  logic unused_err_inject;
  assign unused_err_inject = Err_inject;
  assign Parity_err        = 1'b0;
`endif

endmodule

// File: tb/tb_memoria_instrucoes_param.sv
// Bench for memoria_instrucoes_param: 16x16 instance checked against a behavioural model every cycle,
// plus a 32x64 instance checked with literal expectations.
module tb_memoria_instrucoes_param;
`ifdef MEM_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Rd_en, Wren, Err_inject;
  logic [3:0]  Rd_addr, Wr_addr;
  logic [15:0] Din, Q;
  logic        Q_valid, Ready, Parity_err;

  logic        b_rd_en;
  logic [5:0]  b_rd_addr;
  logic [31:0] b_q;
  logic        b_qv, b_ready, b_pe;

  int errors = 0;
  int checks = 0;

  always #5 Clock = ~Clock;

  memoria_instrucoes_param #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) dut_a (
    .Clock(Clock), .Reset(Reset), .Rd_en(Rd_en), .Rd_addr(Rd_addr), .Q(Q), .Q_valid(Q_valid),
    .Wren(Wren), .Wr_addr(Wr_addr), .Din(Din), .Err_inject(Err_inject), .Ready(Ready),
    .Parity_err(Parity_err));

  memoria_instrucoes_param #(.DATA_WIDTH(32), .ADDR_WIDTH(6)) dut_b (
    .Clock(Clock), .Reset(Reset), .Rd_en(b_rd_en), .Rd_addr(b_rd_addr), .Q(b_q), .Q_valid(b_qv),
    .Wren(1'b0), .Wr_addr(6'd0), .Din(32'd0), .Err_inject(1'b0), .Ready(b_ready),
    .Parity_err(b_pe));

  task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // behavioural model of the 16x16 instance
  logic [15:0] boot_tab [16] = '{16'h40A0, 16'h6000, 16'h40A1, 16'h60A2, 16'h40A0, 16'h40A0,
                                 16'h40A0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
                                 16'h0000, 16'h0000, 16'h0000, 16'h0000};
  logic [15:0] m_mem [16];
  bit          m_bad [16];
  bit          live = 1'b0;
  int          m_boot = 0;
  bit          m_ready, m_qv, m_pe;
  logic [15:0] m_q;

  always @(posedge Clock) begin
    if (!Reset) begin
      live = 1'b1; m_boot = 0; m_ready = 1'b0; m_qv = 1'b0; m_q = 16'h0; m_pe = 1'b0;
    end else if (live) begin
      if (m_boot < 16) begin
        m_mem[m_boot] = boot_tab[m_boot];
        m_bad[m_boot] = 1'b0;
        m_boot++;
        m_ready = (m_boot == 16);
        m_qv = 1'b0; m_pe = 1'b0;
      end else begin
        m_qv = Rd_en;
        m_pe = 1'b0;
        if (Rd_en) begin
          if (Wren && Wr_addr == Rd_addr) begin m_q = Din; m_pe = PAR && Err_inject; end
          else begin m_q = m_mem[Rd_addr]; m_pe = PAR && m_bad[Rd_addr]; end
        end
        if (Wren) begin m_mem[Wr_addr] = Din; m_bad[Wr_addr] = Err_inject; end
      end
    end
  end

  always @(negedge Clock) begin
    if (live) begin
      lit("model_ready", {31'd0, Ready}, {31'd0, m_ready});
      lit("model_q_valid", {31'd0, Q_valid}, {31'd0, m_qv});
      lit("model_q", {16'd0, Q}, {16'd0, m_q});
      lit("model_parity_err", {31'd0, Parity_err}, {31'd0, m_pe});
    end
  end

  task automatic rd(input logic [3:0] a, input logic [15:0] exp, input string nm);
    Rd_en = 1'b1; Rd_addr = a;
    @(negedge Clock);
    Rd_en = 1'b0;
    lit(nm, {16'd0, Q}, {16'd0, exp});
    lit({nm, "_valid"}, {31'd0, Q_valid}, 32'd1);
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d, input logic inj);
    Wren = 1'b1; Wr_addr = a; Din = d; Err_inject = inj;
    @(negedge Clock);
    Wren = 1'b0; Err_inject = 1'b0;
  endtask

  int n, na, nb;

  initial begin
    Reset = 1'b0; Rd_en = 1'b0; Wren = 1'b0; Err_inject = 1'b0;
    Rd_addr = '0; Wr_addr = '0; Din = '0; b_rd_en = 1'b0; b_rd_addr = '0;
    repeat (2) @(negedge Clock);
    lit("reset_ready", {31'd0, Ready}, 32'd0);
    lit("reset_q", {16'd0, Q}, 32'd0);
    Reset = 1'b1;
    n = 0; na = 0; nb = 0;
    while ((!Ready || !b_ready) && n < 200) begin
      @(negedge Clock);
      n++;
      if (Ready && na == 0) na = n;
      if (b_ready && nb == 0) nb = n;
    end
    lit("boot_cycles_16x16", na, 32'd16);
    lit("boot_cycles_32x64", nb, 32'd64);

    rd(4'd0, 16'h40A0, "boot_addr0");
    rd(4'd1, 16'h6000, "boot_addr1");
    rd(4'd2, 16'h40A1, "boot_addr2");
    rd(4'd3, 16'h60A2, "boot_addr3");
    rd(4'd7, 16'h0000, "boot_addr7");
    rd(4'd15, 16'h0000, "boot_addr15");

    b_rd_en = 1'b1; b_rd_addr = 6'd0;
    @(negedge Clock);
    lit("wide_addr0", b_q, 32'h000040A0);
    lit("wide_addr0_valid", {31'd0, b_qv}, 32'd1);
    b_rd_addr = 6'd63;
    @(negedge Clock);
    lit("wide_addr63", b_q, 32'h0);
    b_rd_en = 1'b0;

    wr(4'd5, 16'hBEEF, 1'b0);
    rd(4'd5, 16'hBEEF, "write_then_read");
    Wren = 1'b1; Wr_addr = 4'd9; Din = 16'h1234; Rd_en = 1'b1; Rd_addr = 4'd9;
    @(negedge Clock);
    Wren = 1'b0; Rd_en = 1'b0;
    lit("write_first", {16'd0, Q}, 32'h1234);
    Wren = 1'b1; Wr_addr = 4'd4; Din = 16'h5555; Rd_en = 1'b1; Rd_addr = 4'd0;
    @(negedge Clock);
    Wren = 1'b0; Rd_en = 1'b0;
    lit("diff_addr_read", {16'd0, Q}, 32'h40A0);
    rd(4'd4, 16'h5555, "diff_addr_write");

    Rd_en = 1'b1; Rd_addr = 4'd1;
    @(negedge Clock);
    lit("pulse0_valid", {31'd0, Q_valid}, 32'd1);
    Rd_addr = 4'd2;
    @(negedge Clock);
    lit("pulse1_valid", {31'd0, Q_valid}, 32'd1);
    Rd_en = 1'b0;
    @(negedge Clock);
    lit("idle_valid", {31'd0, Q_valid}, 32'd0);
    lit("idle_q_hold", {16'd0, Q}, 32'h40A1);

    wr(4'd2, 16'h00FF, 1'b1);
    rd(4'd2, 16'h00FF, "parity_inj_read");
    lit("parity_inj", {31'd0, Parity_err}, {31'd0, PAR});
    wr(4'd2, 16'h00FF, 1'b0);
    rd(4'd2, 16'h00FF, "parity_clean_read");
    lit("parity_clean", {31'd0, Parity_err}, 32'd0);
    Wren = 1'b1; Wr_addr = 4'd6; Din = 16'h0001; Err_inject = 1'b1; Rd_en = 1'b1; Rd_addr = 4'd6;
    @(negedge Clock);
    Wren = 1'b0; Err_inject = 1'b0; Rd_en = 1'b0;
    lit("parity_bypass", {31'd0, Parity_err}, {31'd0, PAR});
    rd(4'd0, 16'h40A0, "parity_boot_read");
    lit("parity_boot", {31'd0, Parity_err}, 32'd0);

    Reset = 1'b0;
    @(negedge Clock);
    Reset = 1'b1; Wren = 1'b1; Wr_addr = 4'd3; Din = 16'hFFFF; Rd_en = 1'b1; Rd_addr = 4'd3;
    repeat (7) @(negedge Clock);
    lit("midboot_ready", {31'd0, Ready}, 32'd0);
    Reset = 1'b0;
    @(negedge Clock);
    Reset = 1'b1;
    n = 0;
    while (!Ready && n < 100) begin
      @(negedge Clock);
      n++;
    end
    Wren = 1'b0; Rd_en = 1'b0;
    lit("reboot_cycles", n, 32'd16);
    rd(4'd3, 16'h60A2, "boot_write_lost");
    rd(4'd5, 16'h40A0, "reboot_addr5");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
